// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 streaming convolution engine:
// filter mode encoding, Sobel kernels and datapath width helpers.
package conv_pkg;

   typedef enum logic [1:0] {
      MODE_HORZ = 2'b00,
      MODE_VERT = 2'b01,
      MODE_MAG  = 2'b10,
      MODE_USER = 2'b11
   } mode_e;

   localparam int KERNEL_TAPS = 9;

   // Raster order from the top-left; the top row sees the oldest line.
   localparam int SOBEL_H [KERNEL_TAPS] = '{ 1,  2,  1,
                                             0,  0,  0,
                                            -1, -2, -1};
   localparam int SOBEL_V [KERNEL_TAPS] = '{ 1,  0, -1,
                                             2,  0, -2,
                                             1,  0, -1};

   function automatic int prod_width(input int pix_w, input int coef_w);
      return pix_w + coef_w + 1;
   endfunction

   // Nine products plus headroom: the sum can never overflow.
   function automatic int acc_width(input int pix_w, input int coef_w);
      return prod_width(pix_w, coef_w) + 4;
   endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Two-line circular buffer giving the three vertical taps of a column:
// current pixel, one line back and two lines back.
module conv_line_buffer
   import conv_pkg::*;
#(
   parameter int IMG_W = 1280,
   parameter int PIX_W = 12
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [PIX_W-1:0] din,
   output logic [PIX_W-1:0] tap_cur,
   output logic [PIX_W-1:0] tap_m1,
   output logic [PIX_W-1:0] tap_m2
);

   localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

   logic [PIX_W-1:0] line1 [IMG_W];
   logic [PIX_W-1:0] line2 [IMG_W];
   logic [AW-1:0]    ptr;

   // The slot about to be overwritten holds the pixel exactly one line older.
   assign tap_cur = din;
   assign tap_m1  = line1[ptr];
   assign tap_m2  = line2[ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (en) begin
         ptr <= (ptr == AW'(IMG_W - 1)) ? '0 : ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (en) begin
         line1[ptr] <= din;
         line2[ptr] <= line1[ptr];
      end
   end

endmodule

// File: rtl/conv3x3_stream.sv
// 3x3 streaming convolution: Sobel H/V, |Gh|+|Gv| or a loadable signed kernel,
// 3-cycle latency. Define CONV_USER_KERNEL_EN to build the user-kernel path.
module conv3x3_stream
   import conv_pkg::*;
#(
   parameter int PIX_W     = 12,
   parameter int IMG_W     = 1280,
   parameter int IMG_H     = 960,
   parameter int COEF_W    = 4,
   parameter int OUT_SHIFT = 0
) (
   input  logic                     iCLK,
   input  logic                     iRST,
   input  logic                     iSOF,
   input  logic [PIX_W-1:0]         iDATA,
   input  logic                     iDVAL,
   input  logic [1:0]               iMODE,
   input  logic                     iCOEF_WE,
   input  logic [3:0]               iCOEF_ADDR,
   input  logic [COEF_W-1:0]        iCOEF,
   output logic [PIX_W-1:0]         oDATA,
   output logic                     oDVAL,
   output logic [$clog2(IMG_W)-1:0] oX,
   output logic [$clog2(IMG_H)-1:0] oY
);

   localparam int XW     = $clog2(IMG_W);
   localparam int YW     = $clog2(IMG_H);
   localparam int PROD_W = prod_width(PIX_W, COEF_W);
   localparam int ACC_W  = acc_width(PIX_W, COEF_W);
   localparam int MAG_W  = ACC_W + 1;

   function automatic logic signed [PROD_W-1:0] mul_sobel(input logic [PIX_W-1:0] pix,
                                                           input int coef);
      logic signed [PROD_W-1:0] p;
      p = '0;
      p[PIX_W-1:0] = pix;
      case (coef)
         1:       return p;
         2:       return p <<< 1;
         -1:      return -p;
         -2:      return -(p <<< 1);
         default: return '0;
      endcase
   endfunction

   // ---------------- coordinate counters ----------------
   logic [XW-1:0] cnt_x, cur_x;
   logic [YW-1:0] cnt_y, cur_y;

   always_comb begin
      cur_x = iSOF ? '0 : cnt_x;
      cur_y = iSOF ? '0 : cnt_y;
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         cnt_x <= '0;
         cnt_y <= '0;
      end else if (iDVAL) begin
         if (cur_x == XW'(IMG_W - 1)) begin
            cnt_x <= '0;
            cnt_y <= (cur_y == YW'(IMG_H - 1)) ? '0 : cur_y + 1'b1;
         end else begin
            cnt_x <= cur_x + 1'b1;
            cnt_y <= cur_y;
         end
      end else if (iSOF) begin
         cnt_x <= '0;
         cnt_y <= '0;
      end
   end

   // ---------------- coefficient storage ----------------
`ifdef CONV_USER_KERNEL_EN
   logic signed [COEF_W-1:0] coef_q [KERNEL_TAPS];

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         for (int unsigned i = 0; i < KERNEL_TAPS; i++) coef_q[i] <= '0;
         coef_q[4] <= COEF_W'(1);
      end else if (iCOEF_WE && (iCOEF_ADDR < 4'd9)) begin
         coef_q[iCOEF_ADDR] <= signed'(iCOEF);
      end
   end

   function automatic logic signed [PROD_W-1:0] mul_user(input logic [PIX_W-1:0] pix,
                                                          input logic signed [COEF_W-1:0] coef);
      logic signed [PIX_W:0]    pix_s;
      logic signed [PROD_W-1:0] pe, ce;
      pix_s = signed'({1'b0, pix});
      pe    = PROD_W'(pix_s);
      ce    = PROD_W'(coef);
      return pe * ce;
   endfunction
`else
   logic unused_coef;
   assign unused_coef = ^{iCOEF_WE, iCOEF_ADDR, iCOEF};
`endif

   // ---------------- S0: window capture ----------------
   logic [PIX_W-1:0] tap_cur, tap_m1, tap_m2;
   logic [PIX_W-1:0] win [3][3];
   logic             s0_vld, s0_edge;
   logic [XW-1:0]    s0_x;
   logic [YW-1:0]    s0_y;

   conv_line_buffer #(
      .IMG_W (IMG_W),
      .PIX_W (PIX_W)
   ) u_line_buffer (
      .clk     (iCLK),
      .rst_n   (iRST),
      .en      (iDVAL),
      .din     (iDATA),
      .tap_cur (tap_cur),
      .tap_m1  (tap_m1),
      .tap_m2  (tap_m2)
   );

   always_ff @(posedge iCLK) begin
      if (iDVAL) begin
         for (int unsigned r = 0; r < 3; r++) begin
            win[r][0] <= win[r][1];
            win[r][1] <= win[r][2];
         end
         win[0][2] <= tap_m2;
         win[1][2] <= tap_m1;
         win[2][2] <= tap_cur;
      end
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         s0_vld  <= 1'b0;
         s0_edge <= 1'b0;
         s0_x    <= '0;
         s0_y    <= '0;
      end else begin
         s0_vld  <= iDVAL;
         s0_edge <= (cur_x < XW'(2)) || (cur_y < YW'(2));
         s0_x    <= cur_x;
         s0_y    <= cur_y;
      end
   end

   // ---------------- S1: products ----------------
   // Bank A carries the selected kernel; bank B is always vertical Sobel,
   // only summed in for the magnitude mode.
   mode_e                    mode_in;
   logic signed [PROD_W-1:0] prod_a_d [KERNEL_TAPS];
   logic signed [PROD_W-1:0] prod_b_d [KERNEL_TAPS];
   logic signed [PROD_W-1:0] prod_a   [KERNEL_TAPS];
   logic signed [PROD_W-1:0] prod_b   [KERNEL_TAPS];
   logic                     use_mag;
   logic                     s1_vld, s1_edge, s1_mag;
   logic [XW-1:0]            s1_x;
   logic [YW-1:0]            s1_y;

   assign mode_in = mode_e'(iMODE);

   always_comb begin
      use_mag = 1'b0;
      for (int unsigned i = 0; i < KERNEL_TAPS; i++) begin
         prod_a_d[i] = mul_sobel(win[i/3][i%3], SOBEL_H[i]);
         prod_b_d[i] = mul_sobel(win[i/3][i%3], SOBEL_V[i]);
      end
      case (mode_in)
         MODE_VERT: prod_a_d = prod_b_d;
         MODE_MAG:  use_mag = 1'b1;
`ifdef CONV_USER_KERNEL_EN
         MODE_USER: begin
            for (int unsigned i = 0; i < KERNEL_TAPS; i++)
               prod_a_d[i] = mul_user(win[i/3][i%3], coef_q[i]);
         end
`else
         MODE_USER: use_mag = 1'b1;
`endif
         default: ;
      endcase
   end

   always_ff @(posedge iCLK) begin
      prod_a <= prod_a_d;
      prod_b <= prod_b_d;
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         s1_vld  <= 1'b0;
         s1_edge <= 1'b0;
         s1_mag  <= 1'b0;
         s1_x    <= '0;
         s1_y    <= '0;
      end else begin
         s1_vld  <= s0_vld;
         s1_edge <= s0_edge;
         s1_mag  <= use_mag;
         s1_x    <= s0_x;
         s1_y    <= s0_y;
      end
   end

   // ---------------- S2: sum, shift, abs ----------------
   logic signed [ACC_W-1:0] sum_a, sum_b, sh_a, sh_b;
   logic [ACC_W-1:0]        abs_a, abs_b;
   logic [MAG_W-1:0]        mag_d, s2_mag;
   logic                    s2_vld, s2_edge;
   logic [XW-1:0]           s2_x;
   logic [YW-1:0]           s2_y;

   always_comb begin
      sum_a = '0;
      sum_b = '0;
      for (int unsigned i = 0; i < KERNEL_TAPS; i++) begin
         sum_a += ACC_W'(prod_a[i]);
         sum_b += ACC_W'(prod_b[i]);
      end
      sh_a  = sum_a >>> OUT_SHIFT;
      sh_b  = sum_b >>> OUT_SHIFT;
      abs_a = sh_a[ACC_W-1] ? -sh_a : sh_a;
      abs_b = sh_b[ACC_W-1] ? -sh_b : sh_b;
      mag_d = s1_mag ? ({1'b0, abs_a} + {1'b0, abs_b}) : {1'b0, abs_a};
   end

   always_ff @(posedge iCLK) begin
      s2_mag <= mag_d;
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         s2_vld  <= 1'b0;
         s2_edge <= 1'b0;
         s2_x    <= '0;
         s2_y    <= '0;
      end else begin
         s2_vld  <= s1_vld;
         s2_edge <= s1_edge;
         s2_x    <= s1_x;
         s2_y    <= s1_y;
      end
   end

   // ---------------- S3: saturate, mask, output ----------------
   logic [PIX_W-1:0] sat_d;

   always_comb begin
      sat_d = (|s2_mag[MAG_W-1:PIX_W]) ? '1 : s2_mag[PIX_W-1:0];
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         oDATA <= '0;
         oDVAL <= 1'b0;
         oX    <= '0;
         oY    <= '0;
      end else begin
         oDVAL <= s2_vld;
         if (s2_vld) begin
            oDATA <= s2_edge ? '0 : sat_d;
            oX    <= s2_x;
            oY    <= s2_y;
         end
      end
   end

endmodule

// File: doc/conv3x3_stream.md
# conv3x3_stream

Parametrised 3×3 streaming convolution engine for the camera pixel path. It sits after grey conversion and before the VGA/frame-buffer writer. It keeps its own pixel coordinates and two line buffers. It applies horizontal Sobel, vertical Sobel, gradient magnitude or a run-time-loaded signed kernel, and emits one saturated, border-masked result per accepted input pixel.

## Interface
- PIX_W, 12: pixel width in bits (unsigned) on input and output.
- IMG_W, 1280: active pixels per line; sets the line-buffer depth.
- IMG_H, 960: active lines per frame.
- COEF_W, 4: signed width of each user-kernel coefficient.
- OUT_SHIFT, 0: arithmetic right shift applied to the filter result before abs/saturation.
- iCLK  in  1  clock.
- iRST  in  1  reset, asynchronous, active-low.
- iSOF  in  1  start of frame; synchronous clear of the coordinate counters.
- iDATA  in  PIX_W  grey pixel.
- iDVAL  in  1  pixel valid; one pixel is accepted per cycle while high.
- iMODE  in  2  00 horizontal Sobel, 01 vertical Sobel, 10 |Gh|+|Gv|, 11 user kernel.
- iCOEF_WE  in  1  coefficient write strobe.
- iCOEF_ADDR  in  4  coefficient index 0..8, raster order from top-left; 9..15 are ignored.
- iCOEF  in  COEF_W  signed coefficient value.
- oDATA  out  PIX_W  filtered pixel.
- oDVAL  out  1  output valid.
- oX  out  $clog2(IMG_W)  column of the input pixel this result is aligned to.
- oY  out  $clog2(IMG_H)  row of the input pixel this result is aligned to.

## Operation
- Coordinate counters X and Y advance only on accepted pixels (iDVAL=1).
  - X wraps IMG_W-1→0 and increments Y.
  - Y wraps IMG_H-1→0.
- iSOF=1 forces the current pixel to be (0,0) when iDVAL is also high; the next pixel is (1,0). iSOF with iDVAL=0 sets both counters to 0.
- The line buffer shifts only on iDVAL. The 3×3 window slides one column per accepted pixel.
- The result aligned to input (x,y) is the kernel centred at (x-1,y-1). Top row of the window = oldest line.
- Kernels:
  - Horizontal Sobel: [1 2 1; 0 0 0; -1 -2 -1].
  - Vertical Sobel: [1 0 -1; 2 0 -2; 1 0 -1].
  - Mode 10 computes both in parallel and sums their absolute values.
- Pixels are zero-extended to signed before multiplication.
  - Product width: PIX_W+COEF_W+1.
  - Accumulator width: product width + 4 (no internal overflow).
- Output path, in order: arithmetic shift by OUT_SHIFT, then absolute value, then saturate to 2^PIX_W-1.
- Border mask: x<2 or y<2 forces oDATA=0. oDVAL stays asserted for these pixels.
- iMODE and the coefficients are sampled per pixel at the product stage.
  - Changes take effect on the next pixel entering that stage.
  - Software changes them only between frames.
- A coefficient write takes effect for pixels reaching the product stage from the cycle after the write.
- Reset values:
  - oDATA=0, oDVAL=0, oX=0, oY=0.
  - Counters 0; pipeline valid bits 0.
  - Coefficients: identity kernel (index 4 = 1, all others 0).
- Line-buffer RAM is not cleared; stale data is hidden by the y<2 mask.

## Timing
- Fixed latency of 3 cycles: iDVAL sampled at edge k gives oDVAL=1 after edge k+3, with matching oX/oY/oDATA.
- Pipeline stages:
  - S0: window capture.
  - S1: products.
  - S2: sum, shift and abs.
  - S3: saturate, mask and output register.
- The pipeline always advances; valid bits track bubbles. Gaps in iDVAL produce oDVAL gaps of identical shape and do not alter any result.
- Line-buffer taps are available in the same cycle as the iDATA they align with.
- iRST asserted mid-frame clears all valid bits and the outputs immediately. After release, the first pixel must be preceded by or coincide with iSOF.

## Configuration
- CONV_USER_KERNEL_EN defined: the 9-entry coefficient register file and mode 11 are present.
- CONV_USER_KERNEL_EN undefined:
  - No coefficient storage; iCOEF_WE, iCOEF_ADDR and iCOEF are ignored.
  - iMODE=11 behaves as 10.
  - Multipliers reduce to shift/add.

## Structure
- Shared package conv_pkg holds:
  - the mode enum (MODE_HORZ, MODE_VERT, MODE_MAG, MODE_USER);
  - the Sobel coefficient constants;
  - the accumulator width function.
- Sub-module conv_line_buffer: a two-line, IMG_W-deep, PIX_W-wide shift buffer with clock enable. It provides the three vertical taps (current, −1 line, −2 lines).

## Test plan
All scenarios use IMG_W=16, IMG_H=8 and PIX_W=12 unless stated.
- Constant frame of 100 in every mode 00/01/10 → oDATA=0 for all pixels. oDVAL count = 128.
- Vertical step (cols 0..7 = 0, cols 8..15 = 100), mode 01, rows y≥2:
  - oDATA=400 at x=8 and x=9;
  - 0 elsewhere;
  - mode 00 gives 0 everywhere.
- PIX_W=8 step 0→255, mode 10 → raw value 1020 saturates to oDATA=255.
- User kernel: write index 4 = 2 and all others 0, mode 11 → oDATA at (x,y) = 2× input pixel (x-1,y-1), saturated. x<2 or y<2 gives 0.
- Random iDVAL gaps (≈50% duty) on the vertical-step frame → oDATA sequence identical to the gap-free run. Every output appears exactly 3 cycles after its input.
- iRST pulsed at pixel (5,3), then iSOF → oDVAL=0 during reset. The next frame's results match a clean frame, and rows 0–1 are zero.
